microwave_timer: RTL and testbench

- Downstream consumer of the keypad input encoder. Takes its `load` strobe, its BCD `digit`, and its `pgt_1hz` tick.
- Keys in digits into a 3-digit M:SS BCD register, then counts it down once per second after `start`.
- Drives the display/decoder stage with BCD digits and exposes `running`/`done` status to the top-level controller.

---
 rtl/microwave_timer_pkg.sv | 36 +++
 rtl/microwave_timer_sync_edge.sv | 37 +++
 rtl/microwave_timer.sv | 150 +++++++++++++++
 tb/tb_microwave_timer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_timer_pkg.sv
// Shared types and constants for the microwave countdown timer:
// controller states, BCD limits and the packed M:SS digit record.
package microwave_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    typedef struct packed {
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mss_t;

    // Keyed entries such as 1:75 are legal until start; clamp them to x:59.
    function automatic mss_t normalise(input mss_t v);
        mss_t r;
        r = v;
        if (v.sec_tens > BCD_MAX_TENS) begin
            r.sec_tens = BCD_MAX_TENS;
            r.sec_ones = BCD_MAX_ONES;
        end
        return r;
    endfunction

    function automatic logic is_zero(input mss_t v);
        return (v.min_ones == 4'd0) && (v.sec_tens == 4'd0) && (v.sec_ones == 4'd0);
    endfunction

endpackage

// File: rtl/microwave_timer_sync_edge.sv
// Multi-flop synchronizer with rising-edge detector producing a 1-cycle pulse.
// After clear the input must be seen low before any edge is reported.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // fill_q marks when sync_q carries real samples again after a clear; a
    // level held high across clear therefore never counts as a new edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/microwave_timer.sv
// Keypad-loaded M:SS BCD countdown timer with run/pause/done control,
// counting down once per rising edge of the 1 Hz input.
module microwave_timer
    import microwave_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       pgt_1hz,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    logic load_p;
    logic tick_p;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_edge (
        .clk   (clk),
        .clear (clear),
        .d     (load),
        .pulse (load_p)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_edge (
        .clk   (clk),
        .clear (clear),
        .d     (pgt_1hz),
        .pulse (tick_p)
    );

    // Same depth as the load synchronizer so key_digit lines up with load_p.
    logic [SYNC_STAGES-1:0][3:0] digit_pipe;
    logic [3:0]                  key_digit;

    always_ff @(posedge clk) begin
        if (clear) begin
            digit_pipe <= '0;
        end else begin
            digit_pipe <= {digit_pipe[SYNC_STAGES-2:0], digit};
        end
    end

    assign key_digit = digit_pipe[SYNC_STAGES-1];

    state_t state_q, state_d;
    mss_t   mss_q, mss_d;
    logic   stop_prev_q;

    mss_t   shifted;
    mss_t   dec;
    logic   key_ok;
    logic   stop_rise;

    always_comb begin
        state_d   = state_q;
        mss_d     = mss_q;
        shifted   = mss_t'({mss_q.sec_tens, mss_q.sec_ones, key_digit});
        key_ok    = load_p && (key_digit <= BCD_MAX_ONES);
        stop_rise = stop && !stop_prev_q;

        dec = mss_q;
        if (mss_q.sec_ones != 4'd0) begin
            dec.sec_ones = mss_q.sec_ones - 4'd1;
        end else begin
            dec.sec_ones = BCD_MAX_ONES;
            if (mss_q.sec_tens != 4'd0) begin
                dec.sec_tens = mss_q.sec_tens - 4'd1;
            end else begin
                dec.sec_tens = BCD_MAX_TENS;
                dec.min_ones = mss_q.min_ones - 4'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (stop) begin
                    mss_d = '0;
                end else if (start) begin
                    if (!is_zero(mss_q)) begin
                        mss_d   = normalise(mss_q);
                        state_d = RUN;
                    end
                end else if (key_ok) begin
                    mss_d = shifted;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (tick_p) begin
                    mss_d = dec;
                    if (is_zero(dec)) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                // PAUSE is entered on a stop level, so only a fresh press clears.
                if (stop_rise) begin
                    mss_d   = '0;
                    state_d = IDLE;
                end else if (start && !stop) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                mss_d = '0;
                if (stop) begin
                    state_d = IDLE;
                end else if (load_p) begin
                    state_d = IDLE;
                    if (key_ok) begin
                        mss_d = mss_t'({4'd0, 4'd0, key_digit});
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mss_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            mss_q       <= '0;
            stop_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mss_q       <= mss_d;
            stop_prev_q <= stop;
        end
    end

    assign min_ones = mss_q.min_ones;
    assign sec_tens = mss_q.sec_tens;
    assign sec_ones = mss_q.sec_ones;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer: a table of operations with expected
// display/status, plus hand-timed sequences for expiry latency and clear.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       pgt_1hz = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       running, done;

    microwave_timer #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .clear    (clear),
        .load     (load),
        .digit    (digit),
        .pgt_1hz  (pgt_1hz),
        .start    (start),
        .stop     (stop),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done)
    );

    always #10 clk = ~clk;

    localparam int OP_KEY   = 0;
    localparam int OP_START = 1;
    localparam int OP_STOP  = 2;
    localparam int OP_TICK  = 3;
    localparam int OP_BOTH  = 4;

    typedef struct {
        int         op;
        logic [3:0] d;
        int         n;
        logic [3:0] em;
        logic [3:0] et;
        logic [3:0] eo;
        logic       er;
        logic       ed;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    task automatic add(input int op, input logic [3:0] d, input int n,
                       input logic [3:0] em, input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ed, input string name);
        vec_t v;
        v.op = op; v.d = d; v.n = n;
        v.em = em; v.et = et; v.eo = eo; v.er = er; v.ed = ed; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] em, input logic [3:0] et,
                         input logic [3:0] eo, input logic er, input logic ed);
        total++;
        if ({min_ones, sec_tens, sec_ones, running, done} !== {em, et, eo, er, ed}) begin
            bad++;
            $display("FAIL %s: got %h:%h%h run=%b done=%b, want %h:%h%h run=%b done=%b",
                     name, min_ones, sec_tens, sec_ones, running, done, em, et, eo, er, ed);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_key(input logic [3:0] d);
        digit = d;
        load  = 1'b1;
        cycles(10);
        load  = 1'b0;
        cycles(5);
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            pgt_1hz = 1'b1;
            cycles(4);
            pgt_1hz = 1'b0;
            cycles(4);
        end
    endtask

    task automatic do_pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        cycles(1);
        start = 1'b0;
        stop  = 1'b0;
        cycles(2);
    endtask

    initial begin
        // Key entry, invalid key, clear from IDLE, start at zero
        add(OP_KEY,   4'd1, 1, 4'd0, 4'd0, 4'd1, 0, 0, "key_1");
        add(OP_KEY,   4'd3, 1, 4'd0, 4'd1, 4'd3, 0, 0, "key_3");
        add(OP_KEY,   4'd0, 1, 4'd1, 4'd3, 4'd0, 0, 0, "key_0_130");
        add(OP_KEY,   4'hC, 1, 4'd1, 4'd3, 4'd0, 0, 0, "key_C_ignored");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "idle_stop_clears");
        add(OP_START, 4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "start_at_zero");
        add(OP_KEY,   4'd5, 1, 4'd0, 4'd0, 4'd5, 0, 0, "key_after_zero_start");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "idle_stop_clears2");
        // Countdown across the minute borrow
        add(OP_KEY,   4'd1, 1, 4'd0, 4'd0, 4'd1, 0, 0, "k100_a");
        add(OP_KEY,   4'd0, 1, 4'd0, 4'd1, 4'd0, 0, 0, "k100_b");
        add(OP_KEY,   4'd0, 1, 4'd1, 4'd0, 4'd0, 0, 0, "k100_c");
        add(OP_START, 4'd0, 1, 4'd1, 4'd0, 4'd0, 1, 0, "run_100");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd5, 4'd9, 1, 0, "tick_059");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd5, 4'd8, 1, 0, "tick_058");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd5, 4'd7, 1, 0, "tick_057");
        add(OP_KEY,   4'd9, 1, 4'd0, 4'd5, 4'd7, 1, 0, "run_key_ignored");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd5, 4'd7, 0, 0, "run_stop_pause");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "pause_stop_clears");
        // Pause / resume at 0:45
        add(OP_KEY,   4'd4, 1, 4'd0, 4'd0, 4'd4, 0, 0, "k45_a");
        add(OP_KEY,   4'd5, 1, 4'd0, 4'd4, 4'd5, 0, 0, "k45_b");
        add(OP_START, 4'd0, 1, 4'd0, 4'd4, 4'd5, 1, 0, "run_045");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd4, 4'd5, 0, 0, "pause_045");
        add(OP_TICK,  4'd0, 5, 4'd0, 4'd4, 4'd5, 0, 0, "pause_5_ticks");
        add(OP_KEY,   4'd9, 1, 4'd0, 4'd4, 4'd5, 0, 0, "pause_key_ignored");
        add(OP_START, 4'd0, 1, 4'd0, 4'd4, 4'd5, 1, 0, "resume_045");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd4, 4'd4, 1, 0, "tick_044");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd4, 4'd4, 0, 0, "pause_044");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "pause_restop_idle");
        // Expiry and leaving DONE with a key
        add(OP_KEY,   4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "k02_a");
        add(OP_KEY,   4'd2, 1, 4'd0, 4'd0, 4'd2, 0, 0, "k02_b");
        add(OP_START, 4'd0, 1, 4'd0, 4'd0, 4'd2, 1, 0, "run_002");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd0, 4'd1, 1, 0, "tick_001");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 1, "tick_done");
        add(OP_TICK,  4'd0, 2, 4'd0, 4'd0, 4'd0, 0, 1, "done_holds");
        add(OP_KEY,   4'd7, 1, 4'd0, 4'd0, 4'd7, 0, 0, "done_key_to_idle");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "idle_stop_clears3");
        // Normalisation of 1:75 and the tens borrow
        add(OP_KEY,   4'd1, 1, 4'd0, 4'd0, 4'd1, 0, 0, "k175_a");
        add(OP_KEY,   4'd7, 1, 4'd0, 4'd1, 4'd7, 0, 0, "k175_b");
        add(OP_KEY,   4'd5, 1, 4'd1, 4'd7, 4'd5, 0, 0, "k175_c");
        add(OP_START, 4'd0, 1, 4'd1, 4'd5, 4'd9, 1, 0, "norm_159");
        add(OP_TICK,  4'd0, 1, 4'd1, 4'd5, 4'd8, 1, 0, "tick_158");
        add(OP_STOP,  4'd0, 1, 4'd1, 4'd5, 4'd8, 0, 0, "pause_158");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "clear_158");
        add(OP_KEY,   4'd1, 1, 4'd0, 4'd0, 4'd1, 0, 0, "k10_a");
        add(OP_KEY,   4'd0, 1, 4'd0, 4'd1, 4'd0, 0, 0, "k10_b");
        add(OP_START, 4'd0, 1, 4'd0, 4'd1, 4'd0, 1, 0, "run_010");
        add(OP_TICK,  4'd0, 1, 4'd0, 4'd0, 4'd9, 1, 0, "tick_009");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd9, 0, 0, "pause_009");
        add(OP_STOP,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "clear_009");
        // start and stop together: stop wins
        add(OP_KEY,   4'd3, 1, 4'd0, 4'd0, 4'd3, 0, 0, "k3");
        add(OP_BOTH,  4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "start_stop_idle");
        add(OP_START, 4'd0, 1, 4'd0, 4'd0, 4'd0, 0, 0, "still_idle");

        clear = 1'b1;
        cycles(3);
        clear = 1'b0;
        cycles(5);
        check("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_KEY:   do_key(vecs[i].d);
                OP_START: do_pulse(1'b1, 1'b0);
                OP_STOP:  do_pulse(1'b0, 1'b1);
                OP_TICK:  do_tick(vecs[i].n);
                OP_BOTH:  do_pulse(1'b1, 1'b1);
                default:  cycles(1);
            endcase
            check(vecs[i].name, vecs[i].em, vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ed);
        end

        // Expiry latency: done asserts on the 3rd clk edge after the tick rises
        do_key(4'd0);
        do_key(4'd2);
        do_pulse(1'b1, 1'b0);
        do_tick(1);
        check("exp_first_tick", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        pgt_1hz = 1'b1;
        cycles(2);
        check("exp_before_edge", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        cycles(1);
        check("exp_on_edge", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        cycles(3);
        pgt_1hz = 1'b0;
        cycles(4);
        do_pulse(1'b0, 1'b1);
        check("done_stop_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Clear mid-run with a key held across it
        do_key(4'd3);
        do_key(4'd0);
        do_pulse(1'b1, 1'b0);
        check("run_030", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        digit = 4'd5;
        load  = 1'b1;
        cycles(6);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("clear_mid_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        cycles(10);
        check("held_key_no_load", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        load = 1'b0;
        cycles(5);
        do_key(4'd4);
        check("key_after_clear", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        digit = 4'd8;
        load  = 1'b1;
        cycles(2);
        check("load_before_edge", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        cycles(1);
        check("load_on_edge", 4'd0, 4'd4, 4'd8, 1'b0, 1'b0);
        cycles(7);
        load = 1'b0;
        cycles(5);
        check("one_shift_per_press", 4'd0, 4'd4, 4'd8, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
